// File: rtl/token_ring_seq.sv
// -----------------------------------------------------------------------------
// token_ring_seq
//
// Parametrised one-hot token sequencer. A single token walks N positions and
// moves one step on each cycle that en is sampled high. There are two walk
// patterns:
//   ring   (mode=0) : 0,1,..,N-1,0,1,..        (wraps forward)
//   bounce (mode=1) : 0,1,..,N-1,N-2,..,1,0,1,.. (ping-pong)
// Each return of the token to position 0 from another position counts as one
// completed lap. A starvation timer raises stall once the token has been
// parked away from home with en low for TMO consecutive cycles.
//
// Parameters:
//   N     : number of token positions (N >= 2)
//   LAP_W : width of the saturating lap counter
//   TMO   : consecutive starved cycles before stall asserts (TMO >= 1)
//
// Ports:
//   clk     in   1      clock
//   rst     in   1      synchronous, active-low reset
//   en      in   1      advance token one position this cycle
//   mode    in   1      0 = ring, 1 = bounce; sampled every cycle
//   state   out  N      one-hot token position, registered
//   home    out  1      state[0]
//   lap_cnt out  LAP_W  completed returns to home, saturating
//   stall   out  1      starvation flag, registered
// -----------------------------------------------------------------------------
module token_ring_seq #(
  parameter int N     = 4,
  parameter int LAP_W = 8,
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  output logic [N-1:0]     state,
  output logic             home,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             stall
);

  // Wide enough to hold the value TMO itself.
  localparam int SW = $clog2(TMO + 1);

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  logic [N-1:0]     state_q,     state_d;
  dir_e             dir_q,       dir_d;
  logic [LAP_W-1:0] lap_cnt_q,   lap_cnt_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             stall_q,     stall_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d     = state_q;
    dir_d       = dir_q;
    lap_cnt_d   = lap_cnt_q;
    stall_cnt_d = stall_cnt_q;

    // Ring mode always walks forward, so the direction is parked at FWD even
    // on idle cycles; a later switch to bounce then starts moving forward.
    if (!mode) begin
      dir_d = DIR_FWD;
    end

    if (en) begin
      if (!mode) begin
        // Rotate left: bit N-1 wraps to bit 0.
        state_d = {state_q[N-2:0], state_q[N-1]};
      end else if (dir_q == DIR_FWD) begin
        if (state_q[N-1]) begin
          state_d = state_q >> 1;
          dir_d   = DIR_REV;
        end else begin
          state_d = state_q << 1;
        end
      end else begin
        if (state_q[0]) begin
          state_d = state_q << 1;
          dir_d   = DIR_FWD;
        end else begin
          state_d = state_q >> 1;
        end
      end
    end

    // A lap completes only when the token arrives at home; departing home or
    // sitting there does not count.
    if (en && state_d[0] && !state_q[0] && (lap_cnt_q != {LAP_W{1'b1}})) begin
      lap_cnt_d = lap_cnt_q + LAP_W'(1);
    end

    // Starvation: token away from home and not allowed to move.
    if (en || state_q[0]) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != SW'(TMO)) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end

    stall_d = (stall_cnt_d == SW'(TMO));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (!rst) begin
      state_q     <= N'(1);
      dir_q       <= DIR_FWD;
      lap_cnt_q   <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      lap_cnt_q   <= lap_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign state   = state_q;
  assign home    = state_q[0];
  assign lap_cnt = lap_cnt_q;
  assign stall   = stall_q;

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot(state_q));

  a_stall_not_home : assert property (@(posedge clk) disable iff (!rst)
    stall_q |-> !state_q[0]);

  // The previous sample must itself be out of reset, otherwise the check
  // would compare against the value that reset just cleared.
  a_lap_monotonic : assert property (@(posedge clk) disable iff (!rst)
    $past(rst) |-> (lap_cnt_q >= $past(lap_cnt_q)));
`endif

`ifdef FORMAL
  // Fairness: en is not withheld forever.
  m_en_fair : assume property (@(posedge clk) s_eventually en);

  // Liveness is stated per walk pattern: alternating modes at the turning
  // points can keep the token bouncing between N-2 and N-1 indefinitely.
  m_mode_stable : assume property (@(posedge clk) disable iff (!rst)
    $stable(mode));

  a_home_live : assert property (@(posedge clk) disable iff (!rst)
    s_eventually state_q[0]);
`endif

endmodule

// File: tb/tb_token_ring_seq.sv
// -----------------------------------------------------------------------------
// tb_token_ring_seq
//
// Directed bench for token_ring_seq with N=4, LAP_W=2, TMO=3. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_token_ring_seq;

  localparam int N     = 4;
  localparam int LAP_W = 2;
  localparam int TMO   = 3;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic [N-1:0]     state;
  logic             home;
  logic [LAP_W-1:0] lap_cnt;
  logic             stall;

  int n_checks = 0;
  int n_pass   = 0;

  token_ring_seq #(
    .N     (N),
    .LAP_W (LAP_W),
    .TMO   (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .state   (state),
    .home    (home),
    .lap_cnt (lap_cnt),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, then step just past the rising edge.
  task automatic tick(input logic e, input logic m);
    en   = e;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst = 1'b1;
  endtask

  // Expected sequences after reset with en=1 every cycle.
  logic [N-1:0] ring_seq   [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [LAP_W-1:0] ring_lap [8] = '{2'd0, 2'd0, 2'd0, 2'd1,
                                     2'd1, 2'd1, 2'd1, 2'd2};
  logic [N-1:0] bnc_seq    [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010};
  logic [LAP_W-1:0] bnc_lap  [7] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                     2'd0, 2'd1, 2'd1};
  logic             stv_stall [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst  = 1'b0;
    en   = 1'b1;
    mode = 1'b0;

    // ---- Reset held with en=1 ------------------------------------------------
    do_reset();
    check("rst_state", 32'(state), 32'h1);
    check("rst_home",  32'(home), 32'h1);
    check("rst_lap",   32'(lap_cnt), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_dir",   32'(dut.dir_q), 32'h0);

    // ---- Ring walk -------------------------------------------------------------
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("ring_state[%0d]", i), 32'(state), 32'(ring_seq[i]));
      check($sformatf("ring_lap[%0d]", i), 32'(lap_cnt), 32'(ring_lap[i]));
    end
    check("ring_home", 32'(home), 32'h1);

    // en=0 holds state and lap count (token at home, no stall)
    tick(1'b0, 1'b0);
    check("hold_state", 32'(state), 32'h1);
    check("hold_lap",   32'(lap_cnt), 32'h2);

    // ---- Bounce walk -----------------------------------------------------------
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1);
      check($sformatf("bnc_state[%0d]", i), 32'(state), 32'(bnc_seq[i]));
      check($sformatf("bnc_lap[%0d]", i), 32'(lap_cnt), 32'(bnc_lap[i]));
      if (i == 3) check("bnc_dir_rev", 32'(dut.dir_q), 32'h1);
      if (i == 6) check("bnc_dir_fwd", 32'(dut.dir_q), 32'h0);
    end

    // ---- Starvation away from home --------------------------------------------
    do_reset();
    tick(1'b1, 1'b0);
    check("stv_start", 32'(state), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check($sformatf("stv_stall[%0d]", i), 32'(stall), 32'(stv_stall[i]));
      check($sformatf("stv_state[%0d]", i), 32'(state), 32'b0010);
    end
    tick(1'b1, 1'b0);
    check("stv_release_stall", 32'(stall), 32'h0);
    check("stv_release_state", 32'(state), 32'b0100);

    // ---- Starvation at home never flags ---------------------------------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check($sformatf("home_stall[%0d]", i), 32'(stall), 32'h0);
    end
    check("home_state", 32'(state), 32'h1);

    // ---- Bounce -> ring while reversing ---------------------------------------
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("sw_pre_state", 32'(state), 32'b0100);
    check("sw_pre_dir",   32'(dut.dir_q), 32'h1);
    tick(1'b1, 1'b0);
    check("sw_state0", 32'(state), 32'b1000);
    check("sw_dir0",   32'(dut.dir_q), 32'h0);
    tick(1'b1, 1'b0);
    check("sw_state1", 32'(state), 32'b0001);
    check("sw_lap",    32'(lap_cnt), 32'h1);

    // Ring mode clears direction even on an idle cycle
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("idle_dir",   32'(dut.dir_q), 32'h0);
    check("idle_state", 32'(state), 32'b0100);
    tick(1'b1, 1'b1);
    check("idle_fwd_state", 32'(state), 32'b1000);

    // ---- Lap saturation, then reset mid-operation ------------------------------
    do_reset();
    for (int i = 0; i < 4 * 5; i++) begin
      tick(1'b1, 1'b0);
      if (i == 11) check("sat_lap3", 32'(lap_cnt), 32'h3);
    end
    check("sat_lap_hold", 32'(lap_cnt), 32'h3);
    check("sat_state",    32'(state), 32'h1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("mid_pre_state", 32'(state), 32'b1000);
    rst = 1'b0;
    tick(1'b1, 1'b1);
    check("mid_rst_state", 32'(state), 32'h1);
    check("mid_rst_dir",   32'(dut.dir_q), 32'h0);
    check("mid_rst_lap",   32'(lap_cnt), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    check("post_rst_state", 32'(state), 32'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/token_ring_seq.md
Name: token_ring_seq

Overview:
Parametrised one-hot token sequencer, the N-position successor of the 3-bit enable-driven state walker used in the fairness labs.
- Modes: ring (wrap) and bounce (ping-pong).
- Counts completed laps.
- Flags enable starvation with a timeout.
- Carries embedded SVA: safety, plus liveness under an enable-fairness assumption.
- Used as the DUT for liveness/fairness formal labs and as a small scheduler token generator.

Parameters:
N, 4, number of token positions (N >= 2)
LAP_W, 8, width of lap counter
TMO, 16, consecutive starved cycles before stall asserts (TMO >= 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
en  input  1  advance token one position this cycle
mode  input  1  0 = ring, 1 = bounce; sampled every cycle
state  output  N  one-hot token position, registered
home  output  1  state[0], combinational from state register
lap_cnt  output  LAP_W  completed returns to home, saturating
stall  output  1  starvation flag, registered

Behaviour:
- Reset is synchronous and active-low on clk; rst=0 at a posedge forces all registers to reset values and overrides every other input.
- Reset values: state = 1 (bit0 set), internal direction dir_q = 0 (forward), lap_cnt = 0, stall = 0, stall counter = 0.
- Advance happens only when en=1 at the posedge; state updates one cycle after en is sampled. With en=0, state, dir_q and lap_cnt hold.
- Ring mode (mode=0): token moves bit i -> bit i+1; bit N-1 -> bit 0. dir_q is forced to 0 on every cycle in ring mode, with or without en.
- Bounce mode (mode=1):
  - dir_q=0: bit i -> i+1 for i < N-1; at bit N-1, next is bit N-2 and dir_q <= 1.
  - dir_q=1: bit i -> i-1 for i > 0; at bit 0, next is bit 1 and dir_q <= 0.
  - N=2 gives the sequence 0,1,0,1, identical to ring.
- Mode switch mid-sequence: the new mode applies to the next advance from the current position.
  - Ring -> bounce continues forward.
  - Bounce -> ring, including while reversing, resumes forward from the current position.
- Lap counting:
  - lap_cnt increments on the cycle the token enters bit 0 from a non-zero position: ring from N-1, bounce from 1.
  - It saturates at 2^LAP_W - 1.
  - Leaving home does not count.
- Stall counter:
  - Increments, saturating at TMO, on each cycle with en=0 and home=0.
  - Clears to 0 on any cycle with en=1 or home=1.
  - stall is registered: stall <= (next counter value == TMO).
  - Consequently stall rises exactly TMO cycles after the first starved cycle, and falls the cycle after en=1 is sampled.
- Invariant: state is one-hot at all times; no zero or multi-hot value is reachable.
- Embedded properties, all disabled while rst=0:
  - Assert: $onehot(state).
  - Assert: stall -> !home.
  - Assert: lap_cnt never decreases, except at reset.
  - Assert (liveness): s_eventually(home).
  - Assume (fairness): s_eventually(en).
  - The liveness assertion must prove in both modes for N in {2,3,4,8}. It must fail (counterexample) when the fairness assumption is removed.

Test Plan:
- Reset: rst=0 for 2 cycles with en=1 -> state=0001, lap_cnt=0, stall=0; first advance occurs the cycle after rst=1.
- Ring, N=4, en=1 continuous, mode=0 -> state 0001,0010,0100,1000,0001; lap_cnt=1 at cycle 4, 2 at cycle 8.
- Bounce, N=4, mode=1, en=1 -> state 0001,0010,0100,1000,0100,0010,0001,0010; lap_cnt=1 on the return to 0001 at cycle 6.
- Starvation, TMO=3: token at 0010, en=0 for 5 cycles -> stall=1 from the 3rd starved cycle; en=1 -> stall=0 the next cycle and token moves to 0100. Repeat with token at home -> stall stays 0.
- Mode switch: bounce, token at 0100 with dir_q=1, switch mode=0 with en=1 -> next state 1000, then 0001, lap_cnt increments.
- Saturation / reset mid-op: LAP_W=2, run ring for 5 laps -> lap_cnt holds 3; assert rst=0 with token at 1000 in bounce -> state=0001, dir_q=0, lap_cnt=0 next cycle.
